// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, types and helpers for the hazard scoreboard.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package hazard_pkg;

   // Forwarding select value meaning "read the register file".
   localparam int FWD_RF = 0;

   // Default-width age and latency types (DEPTH=3 pipeline).
   typedef logic [1:0] age_t;
   typedef logic [1:0] lat_t;

   // Latencies outside 1..depth-1 are treated as the slowest legal class.
   function automatic int clamp_lat(input int lat, input int depth);
      return ((lat < 1) || (lat >= depth)) ? (depth - 1) : lat;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage decode inputs and hazard/forwarding outputs of the scoreboard.
// Latency: wires only.
// Backpressure: stall is the backpressure towards IF/ID.
interface hazard_scoreboard_if #(
   parameter int NREGS = 32,
   parameter int RW    = 5,
   parameter int LW    = 2,
   parameter int SW    = 2,
   parameter int CNTW  = 16
);
   logic             hold;
   logic             flush;
   logic             id_valid;
   logic [RW-1:0]    id_rs1;
   logic [RW-1:0]    id_rs2;
   logic             id_use1;
   logic             id_use2;
   logic             id_wen;
   logic [RW-1:0]    id_rd;
   logic [LW-1:0]    id_lat;
   logic             stall;
   logic             issue;
   logic             id_wb_byp1;
   logic             id_wb_byp2;
   logic [SW-1:0]    ex_fwd1;
   logic [SW-1:0]    ex_fwd2;
   logic [NREGS-1:0] busy_vec;
   logic [CNTW-1:0]  stall_cnt;

   // Pipeline control side: drives decode fields, reads hazard results.
   modport master (
      output hold, flush, id_valid, id_rs1, id_rs2, id_use1, id_use2,
             id_wen, id_rd, id_lat,
      input  stall, issue, id_wb_byp1, id_wb_byp2, ex_fwd1, ex_fwd2,
             busy_vec, stall_cnt
   );

   // Scoreboard side.
   modport slave (
      input  hold, flush, id_valid, id_rs1, id_rs2, id_use1, id_use2,
             id_wen, id_rd, id_lat,
      output stall, issue, id_wb_byp1, id_wb_byp2, ex_fwd1, ex_fwd2,
             busy_vec, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's in-flight writer tracking: busy flag, pipeline age, latency class.
// Latency: state updates on the clock edge after set.
// Backpressure: hold freezes the entry completely.
module sb_entry #(
   parameter int DEPTH = 3,
   parameter int SW    = 2,
   parameter int LW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          set,
   input  logic [LW-1:0] lat_in,
   output logic          busy,
   output logic [SW-1:0] age,
   output logic [LW-1:0] lat
);
   logic          busy_q, busy_d;
   logic [SW-1:0] age_q, age_d;
   logic [LW-1:0] lat_q, lat_d;

   // Next state: a new writer always wins (WAW), otherwise age until WB then retire.
   always_comb begin
      busy_d = busy_q;
      age_d  = age_q;
      lat_d  = lat_q;
      if (!hold) begin
         if (set) begin
            busy_d = 1'b1;
            age_d  = SW'(1);
            lat_d  = lat_in;
         end else if (busy_q) begin
            if (age_q == SW'(DEPTH)) begin
               busy_d = 1'b0;
               age_d  = '0;
            end else begin
               age_d  = age_q + SW'(1);
            end
         end
      end
   end

   // Entry state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         age_q  <= '0;
         lat_q  <= '0;
      end else begin
         busy_q <= busy_d;
         age_q  <= age_d;
         lat_q  <= lat_d;
      end
   end

   assign busy = busy_q;
   assign age  = age_q;
   assign lat  = lat_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard for in-order pipelines: ID stall/issue and registered EX forwarding selects.
// Latency: stall/issue/id_wb_byp combinational; ex_fwd, busy_vec, stall_cnt one cycle.
// Backpressure: stall holds IF/ID and bubbles ID/EX; hold freezes all state.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int RW    = 5,
   parameter int DEPTH = 3,
   parameter int LW    = 2,
   parameter int SW    = 2,
   parameter int CNTW  = 16
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave bus
);
   logic [NREGS-1:0] busy;
   logic [SW-1:0]    age_arr [NREGS];
   logic [LW-1:0]    lat_arr [NREGS];
   logic [LW-1:0]    lat_clamped;
   logic             wr_issue;

   logic [RW-1:0]    src_rs    [2];
   logic             src_use   [2];
   logic             src_stall [2];
   logic             src_byp   [2];
   logic [SW-1:0]    src_fwd   [2];

   logic             stall, issue;
   logic [SW-1:0]    ex_fwd1_q, ex_fwd1_d;
   logic [SW-1:0]    ex_fwd2_q, ex_fwd2_d;
   logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

   assign lat_clamped = LW'(clamp_lat(int'(bus.id_lat), DEPTH));
   assign wr_issue    = issue & bus.id_wen;

   // Register 0 is hard-wired zero and never has a writer.
   assign busy[0]    = 1'b0;
   assign age_arr[0] = '0;
   assign lat_arr[0] = '0;

   for (genvar r = 1; r < NREGS; r++) begin : g_entry
      sb_entry #(.DEPTH(DEPTH), .SW(SW), .LW(LW)) u_entry (
         .clk    (clk),
         .reset  (reset),
         .hold   (bus.hold),
         .set    (wr_issue && (bus.id_rd == RW'(r))),
         .lat_in (lat_clamped),
         .busy   (busy[r]),
         .age    (age_arr[r]),
         .lat    (lat_arr[r])
      );
   end

   assign src_rs[0]  = bus.id_rs1;
   assign src_rs[1]  = bus.id_rs2;
   assign src_use[0] = bus.id_use1;
   assign src_use[1] = bus.id_use2;

   // Per-source hazard check: too young stalls, in flight forwards, at WB bypasses in ID.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_stall[s] = 1'b0;
         src_byp[s]   = 1'b0;
         src_fwd[s]   = SW'(FWD_RF);
         if (src_use[s] && (src_rs[s] != '0) && busy[src_rs[s]]) begin
            if (int'(age_arr[src_rs[s]]) < int'(lat_arr[src_rs[s]])) begin
               src_stall[s] = 1'b1;
            end else if (int'(age_arr[src_rs[s]]) < DEPTH) begin
               src_fwd[s] = age_arr[src_rs[s]] + SW'(1);
            end else begin
               src_byp[s] = 1'b1;
            end
         end
      end
   end

   assign stall = bus.id_valid & (src_stall[0] | src_stall[1]);
   assign issue = bus.id_valid & ~stall & ~bus.flush & ~bus.hold;

   // Forward selects follow the issued instruction into EX; bubbles read the register file.
   always_comb begin
      ex_fwd1_d   = ex_fwd1_q;
      ex_fwd2_d   = ex_fwd2_q;
      stall_cnt_d = stall_cnt_q;
      if (!bus.hold) begin
         ex_fwd1_d = issue ? src_fwd[0] : SW'(FWD_RF);
         ex_fwd2_d = issue ? src_fwd[1] : SW'(FWD_RF);
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
         end
      end
   end

   // EX forwarding selects and saturating stall counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_fwd1_q   <= '0;
         ex_fwd2_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_fwd1_q   <= ex_fwd1_d;
         ex_fwd2_q   <= ex_fwd2_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall      = stall;
   assign bus.issue      = issue;
   assign bus.id_wb_byp1 = src_byp[0];
   assign bus.id_wb_byp2 = src_byp[1];
   assign bus.ex_fwd1    = ex_fwd1_q;
   assign bus.ex_fwd2    = ex_fwd2_q;
   assign bus.busy_vec   = busy;
   assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with DEPTH=3.
// Latency: n/a.
// Backpressure: exercises stall, hold and flush.
module tb_hazard_scoreboard;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   hazard_scoreboard_if #(.NREGS(32), .RW(5), .LW(2), .SW(2), .CNTW(16)) bus ();

   hazard_scoreboard #(
      .NREGS(32), .RW(5), .DEPTH(3), .LW(2), .SW(2), .CNTW(16)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic w, input logic [4:0] rd, input logic [1:0] lat);
      bus.id_valid = v;
      bus.id_rs1   = rs1;
      bus.id_use1  = u1;
      bus.id_rs2   = rs2;
      bus.id_use2  = u2;
      bus.id_wen   = w;
      bus.id_rd    = rd;
      bus.id_lat   = lat;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus.hold  = 1'b0;
      bus.flush = 1'b0;
      idle();

      // Reset state
      #12;
      set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 2'd1);
      #1;
      check("rst_busy_vec", bus.busy_vec, 32'h0);
      check("rst_ex_fwd1", bus.ex_fwd1, 32'd0);
      check("rst_ex_fwd2", bus.ex_fwd2, 32'd0);
      check("rst_stall_cnt", bus.stall_cnt, 32'd0);
      check("rst_stall", bus.stall, 32'd0);
      check("rst_issue", bus.issue, 32'd1);
      idle();
      #9;
      reset = 1'b1;
      tick();

      // 1. ALU producer then immediate consumer
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 2'd1);
      #1;
      check("t1_issue_w", bus.issue, 32'd1);
      tick();
      check("t1_busy3", bus.busy_vec, 32'h8);
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
      #1;
      check("t1_stall", bus.stall, 32'd0);
      check("t1_issue_c", bus.issue, 32'd1);
      tick();
      check("t1_ex_fwd1", bus.ex_fwd1, 32'd2);
      idle();
      tick();
      check("t1_bubble_fwd1", bus.ex_fwd1, 32'd0);
      check("t1_busy_age3", bus.busy_vec, 32'h8);
      tick();
      check("t1_retired", bus.busy_vec, 32'h0);

      // 2. Load-use stall of one cycle
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 2'd2);
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 2'd0);
      #1;
      check("t2_stall", bus.stall, 32'd1);
      check("t2_issue_blk", bus.issue, 32'd0);
      tick();
      check("t2_bubble_fwd2", bus.ex_fwd2, 32'd0);
      check("t2_cnt1", bus.stall_cnt, 32'd1);
      check("t2_stall_clr", bus.stall, 32'd0);
      check("t2_issue", bus.issue, 32'd1);
      tick();
      check("t2_ex_fwd2", bus.ex_fwd2, 32'd3);
      check("t2_cnt_hold", bus.stall_cnt, 32'd1);
      idle();
      tick();
      check("t2_retired", bus.busy_vec, 32'h0);

      // 3. Distance three: consumer meets the writer in WB
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 2'd1);
      tick();
      idle();
      tick();
      tick();
      set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 2'd0);
      #1;
      check("t3_byp1", bus.id_wb_byp1, 32'd1);
      check("t3_byp2_unused", bus.id_wb_byp2, 32'd0);
      check("t3_stall", bus.stall, 32'd0);
      check("t3_busy7", bus.busy_vec, 32'h80);
      tick();
      check("t3_ex_fwd1", bus.ex_fwd1, 32'd0);
      check("t3_retired", bus.busy_vec, 32'h0);
      idle();

      // 4. WAW: younger writer owns the entry; rd=0 never busy
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 2'd2);
      tick();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 2'd1);
      tick();
      set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 2'd1);
      #1;
      check("t4_stall", bus.stall, 32'd0);
      tick();
      check("t4_ex_fwd1", bus.ex_fwd1, 32'd2);
      check("t4_ex_fwd2", bus.ex_fwd2, 32'd2);
      check("t4_busy_r0", bus.busy_vec, 32'h10);
      idle();
      tick();
      tick();
      check("t4_retired", bus.busy_vec, 32'h0);

      // 5. hold during a load-use stall, then flush
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 2'd1);
      tick();
      set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 2'd2);
      tick();
      check("t5_pre_fwd1", bus.ex_fwd1, 32'd2);
      set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
      bus.hold = 1'b1;
      #1;
      check("t5_stall_hold", bus.stall, 32'd1);
      check("t5_issue_hold", bus.issue, 32'd0);
      repeat (4) tick();
      check("t5_frz_fwd1", bus.ex_fwd1, 32'd2);
      check("t5_frz_cnt", bus.stall_cnt, 32'd1);
      check("t5_frz_stall", bus.stall, 32'd1);
      check("t5_frz_busy", bus.busy_vec, 32'h44);
      bus.hold = 1'b0;
      tick();
      check("t5_cnt2", bus.stall_cnt, 32'd2);
      check("t5_bubble_fwd1", bus.ex_fwd1, 32'd0);
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'd1);
      bus.flush = 1'b1;
      #1;
      check("t5_flush_issue", bus.issue, 32'd0);
      tick();
      check("t5_flush_busy", bus.busy_vec, 32'h40);
      bus.flush = 1'b0;
      idle();
      tick();
      check("t5_retired", bus.busy_vec, 32'h0);

      // 6. Asynchronous reset with three writers in flight
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 2'd1);
      tick();
      set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 2'd1);
      tick();
      set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 2'd2);
      tick();
      set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0);
      #1;
      check("t6_pre_busy", bus.busy_vec, 32'h1C00);
      check("t6_pre_stall", bus.stall, 32'd1);
      check("t6_pre_fwd1", bus.ex_fwd1, 32'd2);
      reset = 1'b0;
      #1;
      check("t6_busy", bus.busy_vec, 32'h0);
      check("t6_fwd1", bus.ex_fwd1, 32'd0);
      check("t6_fwd2", bus.ex_fwd2, 32'd0);
      check("t6_stall", bus.stall, 32'd0);
      check("t6_cnt", bus.stall_cnt, 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
